// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: accepts words over valid/ready and emits one bit per
// clock, with a one-word holding buffer so consecutive words stream gap-free.
`timescale 1ns/1ps
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_active,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [WIDTH-1:0] hbuf, hbuf_nx;
  logic             hfull, hfull_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             xfer;
  logic             last;
  logic [WIDTH-1:0] sreg_shifted;

  assign in_ready     = ~hfull;
  assign xfer         = in_valid & ~hfull;
  assign last         = (cnt == LAST);
  assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      hbuf  <= '0;
      hfull <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
      hbuf  <= hbuf_nx;
      hfull <= hfull_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    sreg_nx    = sreg;
    hbuf_nx    = hbuf;
    hfull_nx   = hfull;
    cnt_nx     = cnt;
    ser_bit    = IDLE_BIT;
    ser_active = 1'b0;
    word_done  = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          sreg_nx  = in_data;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        ser_active = 1'b1;
        ser_bit    = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
        word_done  = last;
        if (!last) begin
          sreg_nx = sreg_shifted;
          cnt_nx  = cnt + CW'(1);
          if (xfer) begin
            hbuf_nx  = in_data;
            hfull_nx = 1'b1;
          end
        end else if (hfull) begin
          // buffered word takes priority; in_ready is low this cycle so no new transfer
          sreg_nx  = hbuf;
          cnt_nx   = '0;
          hfull_nx = 1'b0;
        end else if (xfer) begin
          sreg_nx = in_data;
          cnt_nx  = '0;
        end else begin
          sreg_nx  = '0;
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: MSB-first and LSB-first instances share stimulus and
// are checked against a bit-queue reference model of the feeder.
`timescale 1ns/1ps
module tb_serial_bit_feeder;

  localparam int W = 8;
  localparam bit IDLE = 1'b0;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         rdy_m, bit_m, act_m, done_m;
  logic         rdy_l, bit_l, act_l, done_l;

  int unsigned vectors;
  int unsigned miscompares;
  int unsigned done_cnt;
  int unsigned viol;
  bit          prev_stall;
  logic [W-1:0] prev_data;
  bit          x;

  // Model: the feeder is a bit FIFO; ready while no more than one word is queued.
  bit qm[$];
  bit ql[$];
  bit qlast[$];

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_m), .ser_bit(bit_m), .ser_active(act_m), .word_done(done_m)
  );

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .ser_bit(bit_l), .ser_active(act_l), .word_done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      qm.push_back(w[W-1-i]);
      ql.push_back(w[i]);
      qlast.push_back(i == W - 1);
    end
  endfunction

  function automatic void model_clear();
    qm.delete();
    ql.delete();
    qlast.delete();
  endfunction

  task automatic step(output bit xf);
    bit exp_ready;
    bit have;
    @(negedge clk);
    have      = (qm.size() > 0);
    exp_ready = (qm.size() <= W);
    chk("in_ready_msb", rdy_m, exp_ready);
    chk("in_ready_lsb", rdy_l, exp_ready);
    chk("ser_active_msb", act_m, have);
    chk("ser_active_lsb", act_l, have);
    chk("ser_bit_msb", bit_m, have ? qm[0] : IDLE);
    chk("ser_bit_lsb", bit_l, have ? ql[0] : IDLE);
    chk("word_done_msb", done_m, have && qlast[0]);
    chk("word_done_lsb", done_l, have && qlast[0]);
    if (done_m) done_cnt++;
    if (prev_stall && in_valid && in_data !== prev_data) viol++;
    prev_stall = in_valid && !exp_ready;
    prev_data  = in_data;
    xf = in_valid && exp_ready;
    @(posedge clk);
    if (have) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
      void'(qlast.pop_front());
    end
    if (xf) push_word(in_data);
    #1;
  endtask

  initial begin
    logic [W-1:0] words [3];
    int unsigned  idx;
    int unsigned  guard;
    vectors = 0; miscompares = 0; done_cnt = 0; viol = 0;
    prev_stall = 1'b0; prev_data = '0;
    rst = 1'b0; in_valid = 1'b0; in_data = '0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", rdy_m, 1);
    chk("reset_ser_active", act_m, 0);
    chk("reset_ser_bit", bit_m, IDLE);
    chk("reset_word_done", done_m, 0);
    #1 rst = 1'b1;
    repeat (20) step(x);

    // Single word 0x90
    done_cnt = 0;
    in_valid = 1'b1; in_data = 8'h90;
    step(x);
    chk("single_accept", x, 1);
    in_valid = 1'b0;
    repeat (11) step(x);
    chk("single_done_pulses", done_cnt, 1);

    // 0x90 then 0xA5 offered during the third bit
    in_valid = 1'b1; in_data = 8'h90;
    step(x);
    in_valid = 1'b0;
    repeat (2) step(x);
    in_valid = 1'b1; in_data = 8'hA5;
    step(x);
    chk("second_word_buffered", x, 1);
    in_valid = 1'b0;
    repeat (18) step(x);

    // Sustained back-to-back words
    words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'h81;
    done_cnt = 0; idx = 0; guard = 0;
    in_valid = 1'b1;
    while (idx < 3 && guard < 100) begin
      in_data = words[idx];
      step(x);
      if (x) idx++;
      guard++;
    end
    chk("burst_all_accepted", idx, 3);
    in_valid = 1'b0;
    repeat (30) step(x);
    chk("burst_done_pulses", done_cnt, 3);

    // Async reset mid-word with the buffer full
    in_valid = 1'b1; in_data = 8'hC3;
    step(x);
    in_data = 8'h5A;
    step(x);
    in_valid = 1'b0;
    repeat (3) step(x);
    chk("pre_reset_buffer_full", rdy_m, 0);
    #1 rst = 1'b0;
    #1;
    chk("async_ser_active_msb", act_m, 0);
    chk("async_ser_active_lsb", act_l, 0);
    chk("async_ser_bit", bit_m, IDLE);
    chk("async_in_ready", rdy_m, 1);
    chk("async_word_done", done_m, 0);
    model_clear();
    prev_stall = 1'b0;
    #1 rst = 1'b1;
    repeat (12) step(x);

    // Protocol: data changed while stalled is flagged; a legal hold goes out once
    done_cnt = 0;
    in_valid = 1'b1; in_data = 8'h11;
    step(x);
    in_data = 8'h22;
    step(x);
    in_data = 8'h33;
    step(x);
    chk("stall_seen", x, 0);
    in_data = 8'h44;
    step(x);
    chk("protocol_violation_flagged", viol, 1);
    guard = 0; x = 1'b0;
    while (!x && guard < 50) begin
      step(x);
      guard++;
    end
    chk("held_word_accepted", x, 1);
    in_valid = 1'b0;
    repeat (30) step(x);
    chk("held_done_pulses", done_cnt, 3);

    // Randomized traffic with legal holds
    for (int i = 0; i < 400; i++) begin
      if (!prev_stall) begin
        in_valid = ($urandom % 4) != 0;
        in_data  = W'($urandom);
      end
      step(x);
    end
    in_valid = 1'b0;
    repeat (30) step(x);
    chk("no_extra_violations", viol, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
